// File: rtl/aud_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : aud_sram_arbiter
//  Purpose  : Shares the external 1M x 16 SRAM between recorder sample writes
//             (buffered in a small FIFO) and single-word playback reads.
//  Revision : 1.0
// ============================================================================
module aud_sram_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_CYCLES  = 2,
    parameter int RD_CYCLES  = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clear,
    input  logic                          i_wr_valid,
    input  logic [19:0]                   i_wr_addr,
    input  logic [15:0]                   i_wr_data,
    input  logic                          i_rd_req,
    input  logic [19:0]                   i_rd_addr,
    output logic                          o_rd_busy,
    output logic                          o_rd_valid,
    output logic [15:0]                   o_rd_data,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [20:0]                   o_rec_len,
    output logic [19:0]                   o_SRAM_ADDR,
    inout  wire  [15:0]                   io_SRAM_DQ,
    output logic                          o_SRAM_WE_N,
    output logic                          o_SRAM_OE_N,
    output logic                          o_SRAM_CE_N,
    output logic                          o_SRAM_LB_N,
    output logic                          o_SRAM_UB_N
);

    localparam int                c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]  c_DEPTH     = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]  c_NEAR_FULL = (c_PTR_W+1)'(FIFO_DEPTH - 1);
    localparam logic [7:0]        c_WR_LAST   = 8'(WR_CYCLES - 1);
    localparam logic [7:0]        c_RD_LAST   = 8'(RD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_HOLD  = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [7:0]           r_cnt;

    logic [19:0]          r_fifo_addr [FIFO_DEPTH];
    logic [15:0]          r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_level;
    logic                 r_overflow;

    logic                 r_rd_pending;
    logic [19:0]          r_rd_addr;
    logic                 r_rd_valid;
    logic [15:0]          r_rd_data;

    logic [19:0]          r_sram_addr;
    logic [15:0]          r_dq;
    logic                 r_dq_oe;
    logic                 r_we_n;
    logic                 r_oe_n;
    logic [20:0]          r_rec_len;

    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [20:0]          w_wr_end;

    assign w_full   = (r_level == c_DEPTH);
    assign w_pop    = (r_state == S_IDLE) && (w_next == S_WRITE);
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign w_push   = i_wr_valid && (!w_full || w_pop);
    assign w_drop   = i_wr_valid && w_full && !w_pop;
    assign w_wr_end = {1'b0, r_sram_addr} + 21'd1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_rd_pending && (r_level < c_NEAR_FULL)) begin
                    w_next = S_READ;
                end else if (r_level != '0) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: if (r_cnt == c_WR_LAST) w_next = S_HOLD;
            S_HOLD:  w_next = S_IDLE;
            S_READ:  if (r_cnt == c_RD_LAST) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_clear) begin
            r_fifo_addr[r_wr_ptr] <= i_wr_addr;
            r_fifo_data[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_rd_pending <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_sram_addr  <= '0;
            r_dq         <= '0;
            r_dq_oe      <= 1'b0;
            r_we_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_rec_len    <= '0;
        end else if (i_clear) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_rd_pending <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_dq_oe      <= 1'b0;
            r_we_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_rec_len    <= '0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= 1'b0;

            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push && !w_pop) begin
                r_level <= r_level + (c_PTR_W+1)'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - (c_PTR_W+1)'(1);
            end
            if (w_drop) r_overflow <= 1'b1;

            if (i_rd_req && !r_rd_pending) begin
                r_rd_pending <= 1'b1;
                r_rd_addr    <= i_rd_addr;
            end

            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_WRITE) || (r_state == S_READ)) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_pop) begin
                r_sram_addr <= r_fifo_addr[r_rd_ptr];
                r_dq        <= r_fifo_data[r_rd_ptr];
            end else if ((r_state == S_IDLE) && (w_next == S_READ)) begin
                r_sram_addr <= r_rd_addr;
            end

            if ((r_state == S_HOLD) && (w_wr_end > r_rec_len)) begin
                r_rec_len <= w_wr_end;
            end

            if ((r_state == S_READ) && (w_next == S_IDLE)) begin
                r_rd_data    <= io_SRAM_DQ;
                r_rd_valid   <= 1'b1;
                r_rd_pending <= 1'b0;
            end

            // Strobes are registered from the next state so the pins never glitch.
            r_we_n  <= (w_next != S_WRITE);
            r_oe_n  <= (w_next != S_READ);
            r_dq_oe <= (w_next == S_WRITE) || (w_next == S_HOLD);
        end
    end

    assign io_SRAM_DQ   = r_dq_oe ? r_dq : 16'bz;
    assign o_SRAM_ADDR  = r_sram_addr;
    assign o_SRAM_WE_N  = r_we_n;
    assign o_SRAM_OE_N  = r_oe_n;
    assign o_SRAM_CE_N  = 1'b0;
    assign o_SRAM_LB_N  = 1'b0;
    assign o_SRAM_UB_N  = 1'b0;
    assign o_rd_busy    = r_rd_pending;
    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = r_rd_data;
    assign o_overflow   = r_overflow;
    assign o_fifo_level = r_level;
    assign o_rec_len    = r_rec_len;

endmodule
`default_nettype wire

// File: tb/tb_aud_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aud_sram_arbiter
//  Purpose  : Randomized and directed bench for aud_sram_arbiter with an
//             SRAM model and a transaction-level FIFO/arbitration reference.
//  Revision : 1.0
// ============================================================================
module tb_aud_sram_arbiter;

    localparam int DEPTH = 4;
    localparam int WRC   = 2;
    localparam int RDC   = 2;

    logic        clk = 1'b0;
    logic        rst, clear, wr_valid, rd_req;
    logic [19:0] wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic        rd_busy, rd_valid, overflow;
    logic [15:0] rd_data;
    logic [2:0]  fifo_level;
    logic [20:0] rec_len;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n;

    logic        tb_oe = 1'b0;
    logic [15:0] tb_dq = '0;
    assign sram_dq = tb_oe ? tb_dq : 16'bz;

    always #5 clk = ~clk;

    aud_sram_arbiter #(.FIFO_DEPTH(DEPTH), .WR_CYCLES(WRC), .RD_CYCLES(RDC)) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr),
        .o_rd_busy(rd_busy), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
        .o_overflow(overflow), .o_fifo_level(fifo_level), .o_rec_len(rec_len),
        .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
        .o_SRAM_WE_N(sram_we_n), .o_SRAM_OE_N(sram_oe_n),
        .o_SRAM_CE_N(sram_ce_n), .o_SRAM_LB_N(sram_lb_n), .o_SRAM_UB_N(sram_ub_n)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // SRAM contents as seen by the bench; unwritten words return a fixed pattern.
    logic [15:0] mem [logic [19:0]];

    function automatic logic [15:0] mem_rd(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Reference model state
    logic [19:0] q_addr[$];
    logic [15:0] q_data[$];
    int          m_lvl, we_run, oe_run, rd_wait;
    logic        m_ovf, m_pend, in_write, hold_pend;
    logic [20:0] m_rec, hold_end;
    logic [19:0] m_rd_addr, cur_addr;
    logic [15:0] cur_data;
    logic        prev_we, prev_oe, prev_idle;
    bit          acc_log[$];   // 0 = write, 1 = read
    logic        s_wr, s_clr, s_req;
    logic [19:0] s_waddr, s_raddr;
    logic [15:0] s_wdata;

    task automatic model_reset();
        q_addr.delete(); q_data.delete();
        m_lvl = 0; m_ovf = 0; m_rec = '0; m_pend = 0;
        in_write = 0; hold_pend = 0; we_run = 0; oe_run = 0; rd_wait = 0;
        prev_we = 1; prev_oe = 1; prev_idle = 1; tb_oe = 0;
    endtask

    task automatic monitor_cycle();
        logic we, oe, st_w, st_r, pend_pre, hold_now;
        int   lvl_pre;
        we = sram_we_n; oe = sram_oe_n;
        st_w = !we && prev_we;
        st_r = !oe && prev_oe;
        pend_pre = m_pend; lvl_pre = m_lvl; hold_now = 0;
        if (s_clr) begin
            model_reset();
            check_value("clear_we_n", 32'(we), 32'd1);
            check_value("clear_oe_n", 32'(oe), 32'd1);
            check_value("clear_no_valid", 32'(rd_valid), 32'd0);
        end else begin
            if (hold_pend) begin
                if (hold_end > m_rec) m_rec = hold_end;
                hold_pend = 0;
            end
            if (st_w) begin
                check_value("arb_write_rule", 32'(lvl_pre > 0 && !(pend_pre && lvl_pre < DEPTH-1)), 32'd1);
                check_value("gap_before_write", 32'(prev_idle), 32'd1);
                check_value("pop_nonempty", 32'(q_addr.size() > 0), 32'd1);
                if (q_addr.size() > 0) begin
                    cur_addr = q_addr.pop_front();
                    cur_data = q_data.pop_front();
                    m_lvl--;
                end
                in_write = 1; we_run = 0;
                acc_log.push_back(1'b0);
            end
            if (st_r) begin
                check_value("arb_read_rule", 32'(pend_pre && lvl_pre < DEPTH-1), 32'd1);
                check_value("gap_before_read", 32'(prev_idle), 32'd1);
                oe_run = 0;
                acc_log.push_back(1'b1);
            end
            if (s_wr) begin
                if (lvl_pre == DEPTH && !st_w) m_ovf = 1;
                else begin q_addr.push_back(s_waddr); q_data.push_back(s_wdata); m_lvl++; end
            end
            if (s_req && !pend_pre) begin
                m_pend = 1; m_rd_addr = s_raddr; rd_wait = 0;
            end
            if (!we) begin
                we_run++;
                check_value("write_addr", 32'(sram_addr), 32'(cur_addr));
                check_value("write_dq", 32'(sram_dq), 32'(cur_data));
            end else if (in_write) begin
                check_value("we_low_cycles", 32'(we_run), 32'(WRC));
                check_value("hold_addr", 32'(sram_addr), 32'(cur_addr));
                check_value("hold_dq", 32'(sram_dq), 32'(cur_data));
                mem[cur_addr] = cur_data;
                hold_end = {1'b0, cur_addr} + 21'd1;
                hold_pend = 1; in_write = 0; hold_now = 1;
            end
            if (!oe) begin
                oe_run++;
                check_value("read_addr", 32'(sram_addr), 32'(m_rd_addr));
            end
            if (rd_valid) begin
                check_value("valid_had_pending", 32'(pend_pre), 32'd1);
                check_value("oe_low_cycles", 32'(oe_run), 32'(RDC));
                check_value("read_data", 32'(rd_data), 32'(mem_rd(m_rd_addr)));
                m_pend = 0;
            end else if (pend_pre) begin
                rd_wait++;
                if (rd_wait == 100) check_value("read_timeout", 32'(rd_wait), 32'd0);
            end
        end
        check_value("strobe_exclusive", 32'(!we && !oe), 32'd0);
        check_value("fifo_level", 32'(fifo_level), 32'(m_lvl));
        check_value("overflow", 32'(overflow), 32'(m_ovf));
        check_value("rec_len", 32'(rec_len), 32'(m_rec));
        check_value("rd_busy", 32'(rd_busy), 32'(m_pend));
        prev_we = we; prev_oe = oe; prev_idle = we && oe && !hold_now;
        tb_oe = !oe;
        tb_dq = mem_rd(sram_addr);
    endtask

    always begin
        @(posedge clk);
        s_wr = wr_valid; s_waddr = wr_addr; s_wdata = wr_data;
        s_clr = clear; s_req = rd_req; s_raddr = rd_addr;
        #1;
        if (rst) model_reset();
        else monitor_cycle();
    end

    task automatic push(input logic [19:0] a, input logic [15:0] d);
        wr_valid = 1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(fifo_level == 0 && !rd_busy && sram_we_n && sram_oe_n) && n < 200) begin
            @(negedge clk); n++;
        end
        check_value("idle_within_bound", 32'(n < 200), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic request_read(input logic [19:0] a);
        rd_req = 1; rd_addr = a;
        @(negedge clk);
        rd_req = 0;
    endtask

    initial begin
        int n, m, idx, gap;
        logic [19:0] base, a;
        model_reset();
        rst = 1; clear = 0; wr_valid = 0; wr_addr = '0; wr_data = '0; rd_req = 0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check_value("rst_level", 32'(fifo_level), 32'd0);
        check_value("rst_overflow", 32'(overflow), 32'd0);
        check_value("rst_rec_len", 32'(rec_len), 32'd0);
        check_value("rst_busy", 32'(rd_busy), 32'd0);
        check_value("rst_valid", 32'(rd_valid), 32'd0);
        check_value("rst_rd_data", 32'(rd_data), 32'd0);
        check_value("rst_addr", 32'(sram_addr), 32'd0);
        check_value("rst_we_n", 32'(sram_we_n), 32'd1);
        check_value("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check_value("tied_strobes", 32'({sram_ce_n, sram_lb_n, sram_ub_n}), 32'd0);
        rst = 0;
        @(negedge clk);

        push(20'h00010, 16'hA5C3);
        wait_idle();
        check_value("single_write_rec_len", 32'(rec_len), 32'h11);

        push(20'h00005, 16'h1234);
        wait_idle();
        request_read(20'h00005);
        n = 0;
        while (!rd_valid && n < 50) begin @(negedge clk); n++; end
        check_value("readback_valid", 32'(rd_valid), 32'd1);
        check_value("readback_data", 32'(rd_data), 32'h1234);
        check_value("readback_busy_low", 32'(rd_busy), 32'd0);
        wait_idle();

        // Near-full FIFO with a pending read: one more write before the read.
        m = acc_log.size();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin rd_req = 1; rd_addr = 20'h00101; end
            push(20'h00100 + 20'(i), 16'hC000 + 16'(i));
            rd_req = 0;
        end
        wait_idle();
        idx = -1;
        for (int k = m; k < acc_log.size(); k++) if (acc_log[k] && idx < 0) idx = k - m;
        check_value("arb_level3_read_slot", 32'(idx), 32'd2);

        // Lightly loaded FIFO with a pending read: read goes first.
        m = acc_log.size();
        rd_req = 1; rd_addr = 20'h00102;
        push(20'h00120, 16'h4321);
        rd_req = 0;
        wait_idle();
        check_value("arb_level1_read_first", 32'(acc_log.size() > m && acc_log[m]), 32'd1);

        push(20'hFFFFF, 16'h0F0F);
        wait_idle();
        check_value("max_addr_rec_len", 32'(rec_len), 32'h100000);

        for (int i = 0; i < 8; i++) push(20'h00200 + 20'(i), 16'hD000 + 16'(i));
        check_value("overflow_set", 32'(overflow), 32'd1);
        wait_idle();
        check_value("overflow_sticky", 32'(overflow), 32'd1);
        clear = 1;
        @(negedge clk);
        clear = 0;
        check_value("clear_overflow", 32'(overflow), 32'd0);
        check_value("clear_rec_len", 32'(rec_len), 32'd0);

        push(20'h00030, 16'hBEEF);
        wait_idle();
        push(20'h00040, 16'hCAFE);
        n = 0;
        while (sram_we_n && n < 20) begin @(negedge clk); n++; end
        check_value("mid_write_reached", 32'(sram_we_n), 32'd0);
        clear = 1; wr_valid = 1; wr_addr = 20'h00050; wr_data = 16'h5050;
        @(negedge clk);
        clear = 0; wr_valid = 0;
        check_value("midclr_we_n", 32'(sram_we_n), 32'd1);
        check_value("midclr_level", 32'(fifo_level), 32'd0);
        check_value("midclr_rec_len", 32'(rec_len), 32'd0);
        check_value("midclr_overflow", 32'(overflow), 32'd0);
        repeat (6) @(negedge clk);
        check_value("midclr_push_discarded", 32'(fifo_level), 32'd0);

        push(20'h00007, 16'h7777);
        wait_idle();
        request_read(20'h00007);
        n = 0;
        while (sram_oe_n && n < 20) begin @(negedge clk); n++; end
        check_value("mid_read_reached", 32'(sram_oe_n), 32'd0);
        #2 rst = 1;
        #1;
        check_value("arst_oe_n", 32'(sram_oe_n), 32'd1);
        check_value("arst_we_n", 32'(sram_we_n), 32'd1);
        check_value("arst_busy", 32'(rd_busy), 32'd0);
        check_value("arst_valid", 32'(rd_valid), 32'd0);
        check_value("arst_rec_len", 32'(rec_len), 32'd0);
        check_value("arst_addr", 32'(sram_addr), 32'd0);
        @(negedge clk);
        check_value("arst_no_valid", 32'(rd_valid), 32'd0);
        rst = 0;
        @(negedge clk);

        base = 20'($urandom) & 20'hFFFF0;
        gap = 0;
        for (int c = 0; c < 800; c++) begin
            a = ($urandom % 8 == 0) ? 20'hFFFFF : base + 20'($urandom % 16);
            wr_valid = (gap == 0);
            wr_addr = a;
            wr_data = 16'($urandom);
            if (gap == 0) gap = ($urandom % 10 == 0) ? 0 : int'($urandom_range(5, 12));
            else gap--;
            rd_req = !rd_busy && ($urandom % 4 == 0);
            rd_addr = ($urandom % 8 == 0) ? 20'hFFFFF : base + 20'($urandom % 16);
            clear = ($urandom % 200 == 0);
            @(negedge clk);
        end
        wr_valid = 0; rd_req = 0; clear = 0;
        wait_idle();
        check_value("final_level", 32'(fifo_level), 32'd0);
        check_value("final_busy", 32'(rd_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
